// File: rtl/mont_mult_serial_if.sv
// mont_mult_serial_if: request/response bundle for the serial Montgomery
// multiplier.
//   start/a/b/n      : request, driven by the controller (master)
//   busy/done/result/err : status and response, driven by the multiplier (slave)
interface mont_mult_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (output start, a, b, n, input busy, done, result, err);
    modport slave  (input start, a, b, n, output busy, done, result, err);
endinterface

// File: rtl/mont_mult_serial.sv
// mont_mult_serial: bit-serial radix-2 Montgomery multiplier,
// result = a*b*2^-WIDTH mod n.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active high
//   bus  : mont_mult_serial_if.slave (start, a, b, n in; busy, done, result, err out)
// One multiplier bit per CALC cycle, then one CORR cycle for the final
// conditional subtract. An even modulus is rejected with err on the done pulse.

// Plain ripple-carry adder, one full-adder per bit.
module ripple_carry_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] c;

    assign c[0] = ci;
    for (genvar k = 0; k < W; k++) begin : g_fa
        assign s[k]   = x[k] ^ y[k] ^ c[k];
        assign c[k+1] = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
    end
    assign co = c[W];
endmodule

module mont_mult_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mont_mult_serial_if.slave  bus
);
    localparam int PW = WIDTH + 2;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, CORR} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Adder 0 is shared: P + (a[i] ? b : 0) in CALC, P + ~n + 1 (= P - n) in CORR.
    logic [PW-1:0]    add0_y, t, add1_y, u;
    logic             add0_ci, add0_co, add1_co;
    logic             unused_u_lsb;

    always_comb begin
        add0_y  = '0;
        add0_ci = 1'b0;
        if (state_q == CORR) begin
            add0_y  = ~{2'b00, n_q};
            add0_ci = 1'b1;
        end else if (a_q[i_q]) begin
            add0_y  = {2'b00, b_q};
        end
    end

    ripple_carry_adder #(.W(PW)) u_add0 (
        .x (p_q), .y (add0_y), .ci (add0_ci), .s (t), .co (add0_co)
    );

    // Adding n when T is odd makes U even, so the shift below is exact.
    assign add1_y = t[0] ? {2'b00, n_q} : '0;

    ripple_carry_adder #(.W(PW)) u_add1 (
        .x (t), .y (add1_y), .ci (1'b0), .s (u), .co (add1_co)
    );

    assign unused_u_lsb = u[0];

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.n[0]) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        n_d     = bus.n;
                        p_d     = '0;
                        i_d     = '0;
                        state_d = CALC;
                    end else begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        result_d = '0;
                    end
                end
            end
            CALC: begin
                p_d = {add1_co, u[PW-1:1]};
                i_d = i_q + 1'b1;
                if (i_q == IW'(WIDTH - 1)) state_d = CORR;
            end
            CORR: begin
                // Carry out of P + ~n + 1 means no borrow, i.e. P >= n.
                result_d = add0_co ? t[WIDTH-1:0] : p_q[WIDTH-1:0];
                err_d    = 1'b0;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            i_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            i_q      <= i_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_mont_mult_serial.sv
// tb_mont_mult_serial: directed and random checks of mont_mult_serial at
// WIDTH=4 and WIDTH=8 against an arithmetic Montgomery reference.
module tb_mont_mult_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mont_mult_serial_if #(.WIDTH(4)) if4 ();
    mont_mult_serial_if #(.WIDTH(8)) if8 ();

    mont_mult_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    mont_mult_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    // a*b*R^-1 mod n, with R^-1 found by search.
    function automatic int mont_ref(input int a, input int b, input int n, input int w);
        int r, rinv;
        r = 1 << w;
        rinv = 0;
        for (int k = 0; k < n; k++) if ((k * r) % n == 1) rinv = k;
        return ((a * b) % n) * rinv % n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] n);
        if (w8) begin
            if8.start = st; if8.a = a; if8.b = b; if8.n = n;
        end else begin
            if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.n = n[3:0];
        end
    endtask

    // {busy, done, err, result}
    function automatic logic [10:0] obs(input bit w8);
        if (w8) return {if8.busy, if8.done, if8.err, if8.result};
        return {if4.busy, if4.done, if4.err, 4'b0000, if4.result};
    endfunction

    // Drive start for one edge; with pre=1 the caller is already inside the
    // cycle in which start must be seen (back-to-back).
    task automatic start_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] n, input bit pre);
        if (!pre) @(negedge clk);
        drive(w8, 1'b1, a, b, n);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, a, b, n);
    endtask

    // lat = edges after the start edge until done is visible; bc = busy cycles.
    // inj >= 0 pulses start with other operands at that cycle.
    task automatic wait_done(input bit w8, input int inj, output int lat, output int bc,
                             output logic [7:0] res, output logic e);
        logic [10:0] o;
        lat = -1; bc = 0; res = '0; e = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == inj) drive(w8, 1'b1, 8'h11, 8'h22, 8'h33);
            else if (k == inj + 1) drive(w8, 1'b0, 8'h44, 8'h55, 8'h66);
            o = obs(w8);
            if (o[10]) bc++;
            if (o[9]) begin
                lat = k; res = o[7:0]; e = o[8];
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    int          lat, bc, exp_r, dcnt, bcnt2;
    logic [7:0]  res, ra, rb, rn;
    logic        e;
    logic [10:0] o;

    initial begin
        drive(1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        drive(1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset4_status", 32'(obs(1'b0)), 32'h0);
        chk("reset8_status", 32'(obs(1'b1)), 32'h0);
        rst = 1'b0;

        // 5*7 mod 13, no correction
        start_op(1'b0, 8'd5, 8'd7, 8'd13, 1'b0);
        wait_done(1'b0, -1, lat, bc, res, e);
        chk("w4_5x7_lat", 32'(lat), 32'd5);
        chk("w4_5x7_busy", 32'(bc), 32'd5);
        chk("w4_5x7_res", 32'(res), 32'd3);
        chk("w4_5x7_err", 32'(e), 32'd0);
        @(posedge clk); #1;
        o = obs(1'b0);
        chk("w4_done_pulse", 32'(o[9]), 32'd0);
        chk("w4_res_hold", 32'(o[7:0]), 32'd3);

        // 14*14 mod 15, correction taken
        start_op(1'b0, 8'd14, 8'd14, 8'd15, 1'b0);
        wait_done(1'b0, -1, lat, bc, res, e);
        chk("w4_14x14_res", 32'(res), 32'd1);

        // 12*12 mod 13 then back-to-back 1*1 mod 13
        start_op(1'b0, 8'd12, 8'd12, 8'd13, 1'b0);
        wait_done(1'b0, -1, lat, bc, res, e);
        chk("w4_12x12_res", 32'(res), 32'd9);
        start_op(1'b0, 8'd1, 8'd1, 8'd13, 1'b1);
        wait_done(1'b0, -1, lat, bc, res, e);
        chk("w4_b2b_lat", 32'(lat), 32'd5);
        chk("w4_b2b_res", 32'(res), 32'd9);

        // even modulus
        start_op(1'b0, 8'd5, 8'd7, 8'd12, 1'b0);
        wait_done(1'b0, -1, lat, bc, res, e);
        chk("w4_even_lat", 32'(lat), 32'd0);
        chk("w4_even_busy", 32'(bc), 32'd0);
        chk("w4_even_err", 32'(e), 32'd1);
        chk("w4_even_res", 32'(res), 32'd0);
        start_op(1'b0, 8'd5, 8'd7, 8'd13, 1'b0);
        wait_done(1'b0, -1, lat, bc, res, e);
        chk("w4_after_even_err", 32'(e), 32'd0);
        chk("w4_after_even_res", 32'(res), 32'd3);

        // W8 directed run, then reset mid-CALC
        start_op(1'b1, 8'h2A, 8'h2A, 8'hEF, 1'b0);
        wait_done(1'b1, -1, lat, bc, res, e);
        chk("w8_2a_res", 32'(res), 32'(mont_ref(42, 42, 239, 8)));
        chk("w8_2a_lat", 32'(lat), 32'd9);
        start_op(1'b1, 8'h2A, 8'h2A, 8'hEF, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("w8_rst_status", 32'(obs(1'b1)), 32'h0);
        dcnt = 0; bcnt2 = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            o = obs(1'b1);
            if (o[9]) dcnt++;
            if (o[10]) bcnt2++;
        end
        chk("w8_rst_no_done", 32'(dcnt), 32'd0);
        chk("w8_rst_no_busy", 32'(bcnt2), 32'd0);

        // start pulse while busy is ignored
        start_op(1'b1, 8'd100, 8'd200, 8'd211, 1'b0);
        wait_done(1'b1, 3, lat, bc, res, e);
        chk("w8_ign_res", 32'(res), 32'(mont_ref(100, 200, 211, 8)));
        chk("w8_ign_lat", 32'(lat), 32'd9);
        repeat (3) @(posedge clk);
        #1;
        o = obs(1'b1);
        chk("w8_ign_idle", 32'({o[10], o[9]}), 32'd0);
        chk("w8_ign_hold", 32'(o[7:0]), 32'(mont_ref(100, 200, 211, 8)));

        // random odd moduli
        for (int t = 0; t < 500; t++) begin
            rn = 8'($urandom_range(1, 127) * 2 + 1);
            ra = 8'($urandom % rn);
            rb = 8'($urandom % rn);
            exp_r = mont_ref(int'(ra), int'(rb), int'(rn), 8);
            start_op(1'b1, ra, rb, rn, 1'b0);
            wait_done(1'b1, -1, lat, bc, res, e);
            chk($sformatf("rnd%0d_res(a=%0d,b=%0d,n=%0d)", t, ra, rb, rn), 32'(res), 32'(exp_r));
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'd9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
